// File: rtl/imgproc_ctrl.sv
// Image-processing command controller: decodes host commands into angle/mode
// settings and frame-pass start/abort pulses, counts written pixels and
// signals completion with a one-cycle refresh pulse.
module imgproc_ctrl #(
  parameter int NPIX      = 102400,
  parameter int MAX_ANGLE = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ack,
  output logic       busy,
  output logic       refresh,
  output logic       error,
  output logic       start,
  output logic       abort,
  output logic [6:0] angle,
  output logic [1:0] mode,
  input  logic       wr_strobe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_SET_ANGLE = 4'd0,
    OP_SET_MODE  = 4'd1,
    OP_START     = 4'd2,
    OP_ABORT     = 4'd3,
    OP_CLR_ERR   = 4'd4
  } opcode_t;

  localparam logic [16:0] LAST_PIX  = 17'(NPIX - 1);
  localparam logic [7:0]  MAX_ANG_B = 8'(MAX_ANGLE);

  state_t      state;
  logic        armed;
  logic [16:0] count;

  logic accept;
  logic in_run;
  logic complete;
  logic err_set;
  logic err_clr;

  // Decode the sampled command and the error set/clear conditions for this edge.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    accept   = cmd_valid && armed;
    in_run   = (state == RUN);
    complete = in_run && wr_strobe && (count == LAST_PIX);
    err_set  = wr_strobe && !in_run;
    err_clr  = 1'b0;
    if (accept) begin
      case (cmd)
        OP_SET_ANGLE: if (in_run || cmd_data > MAX_ANG_B) err_set = 1'b1;
        OP_SET_MODE:  if (in_run || cmd_data[7:2] != 6'd0) err_set = 1'b1;
        OP_START:     if (state != IDLE) err_set = 1'b1;
        OP_ABORT:     begin end
        OP_CLR_ERR: begin
          if (in_run) err_set = 1'b1;
          else        err_clr = 1'b1;
        end
        default:      err_set = 1'b1;
      endcase
    end
  end

  // Control FSM, arming, pixel counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b1;
      count   <= '0;
      cmd_ack <= 1'b0;
      busy    <= 1'b0;
      refresh <= 1'b0;
      error   <= 1'b0;
      start   <= 1'b0;
      abort   <= 1'b0;
      angle   <= '0;
      mode    <= '0;
    end else begin
      cmd_ack <= accept;
      start   <= 1'b0;
      abort   <= 1'b0;
      refresh <= 1'b0;

      // A held request executes once; re-arm only after cmd_valid drops.
      if (accept)          armed <= 1'b0;
      else if (!cmd_valid) armed <= 1'b1;

      // Set beats clear when both happen on the same edge.
      if (err_set)      error <= 1'b1;
      else if (err_clr) error <= 1'b0;

      // Datapath settings are frozen while a pass runs.
      if (accept && !in_run && cmd == OP_SET_ANGLE && cmd_data <= MAX_ANG_B)
        angle <= cmd_data[6:0];
      if (accept && !in_run && cmd == OP_SET_MODE && cmd_data[7:2] == 6'd0)
        mode <= cmd_data[1:0];

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (accept && cmd == OP_START) begin
            state <= RUN;
            start <= 1'b1;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        RUN: begin
          // Completion takes priority over an ABORT sampled on the same edge.
          if (complete) begin
            state   <= DONE;
            busy    <= 1'b0;
            refresh <= 1'b1;
            count   <= count + 17'd1;
          end else if (accept && cmd == OP_ABORT) begin
            state <= IDLE;
            busy  <= 1'b0;
            abort <= 1'b1;
            count <= '0;
          end else if (wr_strobe) begin
            count <= count + 17'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imgproc_ctrl.sv
// Scoreboard bench for imgproc_ctrl: every accepted command and every
// frame completion pushes an expected output snapshot, popped and compared
// when the DUT raises cmd_ack or refresh.
module tb_imgproc_ctrl;

  localparam int NPIX      = 1024;
  localparam int MAX_ANGLE = 90;
  localparam int MID       = 500;
  localparam int RST_AT    = 300;

  logic       clk;
  logic       rst_n;
  logic [3:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ack;
  logic       busy;
  logic       refresh;
  logic       error;
  logic       start;
  logic       abort;
  logic [6:0] angle;
  logic [1:0] mode;
  logic       wr_strobe;

  imgproc_ctrl #(.NPIX(NPIX), .MAX_ANGLE(MAX_ANGLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ack   (cmd_ack),
    .busy      (busy),
    .refresh   (refresh),
    .error     (error),
    .start     (start),
    .abort     (abort),
    .angle     (angle),
    .mode      (mode),
    .wr_strobe (wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack;
    logic       refresh;
    logic       start;
    logic       abort;
    logic       busy;
    logic       error;
    logic [6:0] angle;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack = 0, n_start = 0, n_abort = 0, n_refresh = 0;

  // Reference model state
  logic       m_run;
  logic       m_err;
  logic [6:0] m_angle;
  logic [1:0] m_mode;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and compares scoreboard snapshots.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_ack) n_ack++;
      if (start)   n_start++;
      if (abort)   n_abort++;
      if (refresh) n_refresh++;
      if (cmd_ack || refresh) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_ack",     cmd_ack, mon_e.ack);
          check("sb_refresh", refresh, mon_e.refresh);
          check("sb_start",   start,   mon_e.start);
          check("sb_abort",   abort,   mon_e.abort);
          check("sb_busy",    busy,    mon_e.busy);
          check("sb_error",   error,   mon_e.error);
          check("sb_angle",   angle,   mon_e.angle);
          check("sb_mode",    mode,    mon_e.mode);
        end
      end
    end
  end

  task automatic model_reset();
    m_run = 1'b0; m_err = 1'b0; m_angle = '0; m_mode = '0; m_cnt = 0;
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [7:0] data, output exp_t e);
    e = '0;
    case (op)
      4'd0: if (m_run || data > 8'(MAX_ANGLE)) m_err = 1'b1; else m_angle = data[6:0];
      4'd1: if (m_run || data[7:2] != 6'd0) m_err = 1'b1; else m_mode = data[1:0];
      4'd2: if (m_run) m_err = 1'b1;
            else begin e.start = 1'b1; m_run = 1'b1; m_cnt = 0; end
      4'd3: if (m_run) begin e.abort = 1'b1; m_run = 1'b0; m_cnt = 0; end
      4'd4: if (m_run) m_err = 1'b1; else m_err = 1'b0;
      default: m_err = 1'b1;
    endcase
    e.ack   = 1'b1;
    e.busy  = m_run;
    e.error = m_err;
    e.angle = m_angle;
    e.mode  = m_mode;
  endtask

  function automatic exp_t refresh_exp(input logic with_ack);
    exp_t e;
    e = '0;
    e.ack     = with_ack;
    e.refresh = 1'b1;
    e.error   = m_err;
    e.angle   = m_angle;
    e.mode    = m_mode;
    return e;
  endfunction

  // Issue one command, expect ack one edge later, then release and re-arm.
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] data);
    exp_t e;
    int waits;
    model_cmd(op, data, e);
    exp_q.push_back(e);
    cmd = op; cmd_data = data; cmd_valid = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (!cmd_ack && waits < 8);
    check("ack_latency", waits, 1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive n consecutive write strobes, one per cycle.
  task automatic strobe_n(input int n);
    wr_strobe = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (m_run) begin
        m_cnt++;
        if (m_cnt == NPIX) begin
          m_run = 1'b0;
          exp_q.push_back(refresh_exp(1'b0));
        end
      end else begin
        m_err = 1'b1;
      end
      @(posedge clk); #1;
    end
    wr_strobe = 1'b0;
  endtask

  initial begin
    exp_t e;
    int a0, s0, b0, r0;

    rst_n = 1'b0; cmd = '0; cmd_data = '0; cmd_valid = 1'b0; wr_strobe = 1'b0;
    model_reset();
    #1;
    check("rst_ack",     cmd_ack, 0);
    check("rst_busy",    busy,    0);
    check("rst_refresh", refresh, 0);
    check("rst_error",   error,   0);
    check("rst_start",   start,   0);
    check("rst_abort",   abort,   0);
    check("rst_angle",   angle,   0);
    check("rst_mode",    mode,    0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Angle setting, boundary and illegal value
    do_cmd(4'd0, 8'd45);
    do_cmd(4'd0, 8'd91);
    check("angle_kept", angle, 45);
    check("angle_err",  error, 1);
    do_cmd(4'd4, 8'd0);
    check("clr_err", error, 0);
    do_cmd(4'd0, 8'd90);
    check("angle_max", angle, 90);
    do_cmd(4'd0, 8'd45);

    // Mode setting, illegal operand and illegal opcode
    do_cmd(4'd1, 8'd2);
    do_cmd(4'd1, 8'h06);
    check("mode_kept", mode, 2);
    do_cmd(4'd4, 8'd0);
    do_cmd(4'd9, 8'd0);
    check("opcode_err", error, 1);
    do_cmd(4'd4, 8'd0);

    // Spurious write in IDLE, then set-beats-clear on one edge
    strobe_n(1);
    check("spurious_err", error, 1);
    model_cmd(4'd4, 8'd0, e);
    m_err = 1'b1; e.error = 1'b1;
    exp_q.push_back(e);
    cmd = 4'd4; cmd_valid = 1'b1; wr_strobe = 1'b1;
    @(posedge clk); #1;
    check("set_beats_clr_ack", cmd_ack, 1);
    check("set_beats_clr_err", error, 1);
    cmd_valid = 1'b0; wr_strobe = 1'b0;
    @(posedge clk); #1;
    do_cmd(4'd4, 8'd0);

    // Full frame with rejected commands during the pass
    s0 = n_start; r0 = n_refresh;
    do_cmd(4'd2, 8'd0);
    check("frame_busy", busy, 1);
    do_cmd(4'd0, 8'd30);
    do_cmd(4'd4, 8'd0);
    check("run_err", error, 1);
    strobe_n(NPIX);
    check("frame_refresh", refresh, 1);
    check("frame_busy_done", busy, 0);
    @(posedge clk); #1;
    check("refresh_width", refresh, 0);
    check("frame_refresh_cnt", n_refresh - r0, 1);
    check("frame_start_cnt", n_start - s0, 1);
    do_cmd(4'd4, 8'd0);

    // Abort mid-frame, then restart counts from zero
    b0 = n_abort; r0 = n_refresh;
    do_cmd(4'd2, 8'd0);
    strobe_n(MID);
    do_cmd(4'd3, 8'd0);
    check("abort_cnt", n_abort - b0, 1);
    check("abort_busy", busy, 0);
    check("abort_no_refresh", n_refresh - r0, 0);
    do_cmd(4'd2, 8'd0);
    strobe_n(NPIX - 1);
    check("restart_not_done", n_refresh - r0, 0);
    check("restart_busy", busy, 1);
    strobe_n(1);
    check("restart_refresh", refresh, 1);
    @(posedge clk); #1;

    // Held request executes once
    a0 = n_ack; s0 = n_start;
    model_cmd(4'd2, 8'd0, e);
    exp_q.push_back(e);
    cmd = 4'd2; cmd_data = 8'd0; cmd_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("held_ack_cnt", n_ack - a0, 1);
    check("held_start_cnt", n_start - s0, 1);

    // ABORT sampled on the final strobe: completion wins
    b0 = n_abort;
    strobe_n(NPIX - 1);
    m_cnt++; m_run = 1'b0;
    exp_q.push_back(refresh_exp(1'b1));
    cmd = 4'd3; cmd_valid = 1'b1; wr_strobe = 1'b1;
    @(posedge clk); #1;
    check("simul_refresh", refresh, 1);
    check("simul_abort", abort, 0);
    check("simul_ack", cmd_ack, 1);
    cmd_valid = 1'b0; wr_strobe = 1'b0;
    @(posedge clk); #1;
    check("simul_abort_cnt", n_abort - b0, 0);

    // Reset mid-frame abandons the pass
    do_cmd(4'd1, 8'd1);
    do_cmd(4'd2, 8'd0);
    strobe_n(RST_AT);
    b0 = n_abort; r0 = n_refresh;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_ack",     cmd_ack, 0);
    check("mrst_busy",    busy,    0);
    check("mrst_refresh", refresh, 0);
    check("mrst_error",   error,   0);
    check("mrst_start",   start,   0);
    check("mrst_abort",   abort,   0);
    check("mrst_angle",   angle,   0);
    check("mrst_mode",    mode,    0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_refresh", n_refresh - r0, 0);
    check("mrst_no_abort", n_abort - b0, 0);
    do_cmd(4'd0, 8'd10);
    check("post_rst_angle", angle, 10);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
